mealy_fsm: RTL and testbench
============================

// Module: mealy_fsm
// PURPOSE
//  Overlapping serial bit-pattern detector built as a Mealy FSM.
//  Samples one bit per clock on din.
//  Asserts y combinationally in the same cycle that din carries the final bit of PATTERN.
//  Used as a framing/sync-word detector on a 1-bit serial stream.
// PARAMETERS
//  PAT_LEN  4        pattern length in bits, 2..16
//  PATTERN  4'b1011  pattern bits; PATTERN[PAT_LEN-1] is received first
//  OVERLAP  1        1 = overlapping matches allowed; 0 = restart at S0 after a hit
// PORTS
//  clk    in   1  single clock; all state changes on rising edge
//  reset  in   1  asynchronous, active-low reset (0 = reset)
//  din    in   1  serial data bit, sampled at posedge clk
//  y      out  1  match flag, Mealy (combinational from state and din)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - State k (0..PAT_LEN-1) = number of leading pattern bits currently matched.
//  - State register width = clog2(PAT_LEN). S0 = reset state.
//  - Reset asserted: state -> S0 immediately, with no clock required.
//  - Reset asserted: y forced to 0 regardless of din.
//  - Reset deasserted: first bit is sampled at the next rising edge.
//  - Output: y = (state == PAT_LEN-1) && (din == PATTERN[0]).
//    * No registered latency: y reflects the current din within the same cycle.
//    * The bench samples y just before the edge that consumes the final bit.
//  - Next state when din matches the expected bit and state < PAT_LEN-1: state+1.
//  - Next state on a match in the last state:
//    * OVERLAP=1: go to the longest proper prefix of PATTERN that is also a suffix.
//    * OVERLAP=0: go to S0.
//  - Next state on a mismatch: longest prefix of PATTERN equal to a suffix of
//    (matched bits + din), i.e. KMP failure transition. Never blindly S0.
//  - Transition table is computed at elaboration by a constant function; no runtime tables.
//  - Default PATTERN 1011 transitions (din=0 / din=1):
//    * S0 -> S0 / S1
//    * S1 -> S2 / S1
//    * S2 -> S0 / S3
//    * S3 -> S2 (y=0) / S1 (y=1)
//  - X on din: no requirement beyond simulation X-propagation; no default-to-S0 masking.
//  - Illegal state encodings (PAT_LEN not a power of 2): next state S0, y=0.
//  - Parameter checks at elaboration; compile-time error if:
//    * PAT_LEN < 2 or PAT_LEN > 16
//    * PATTERN has set bits above PAT_LEN-1
// STRUCTURE
//  - Package mealy_fsm_pkg holds:
//    * constant function clog2
//    * constant function next_state(pattern, len, state, bit, overlap)
//    * default pattern constants DEF_PAT_LEN=4, DEF_PATTERN=4'b1011
//  - Sub-module mealy_fsm_next: pure combinational state+din -> next_state, y.
//    * Top holds only the async-reset state register and instantiates it.
// TESTING (defaults unless noted; stimulus applied mid-cycle, checked before posedge)
//  1. reset=0 for 2 cycles, din toggling:
//     y=0 throughout; state=S0 after release.
//  2. din stream 1,0,1,1:
//     y=0,0,0,1; y=1 while the 4th bit is on din; y drops to 0 after that edge.
//  3. Overlap, stream 1,0,1,1,0,1,1:
//     y=1 on bits 4 and 7 only.
//  4. OVERLAP=0, same stream:
//     y=1 on bit 4 only.
//  5. Stream 1,0,1, then reset low mid-cycle, release, then stream 1,0,1,1:
//     no y after the first 1; y=1 only on the final 1.
//  6. Stream 1,1,0,1,1 (failure path S1 on a repeated 1):
//     y=1 on bit 5.

Source files
------------

// File: rtl/mealy_fsm_pkg.sv
// mealy_fsm_pkg
//   Shared constants and elaboration-time helpers for the serial pattern
//   detector.
//   - clog2      : state register width for a given pattern length (min 1)
//   - next_state : KMP-style transition for one (state, din) pair; it is only
//                  ever evaluated on constants to build the transition table
//   - def_state_e: state names for the default 4-bit pattern
package mealy_fsm_pkg;

    localparam int          DEF_PAT_LEN = 4;
    localparam logic [3:0]  DEF_PATTERN = 4'b1011;

    typedef enum logic [1:0] {S0, S1, S2, S3} def_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // pattern[len-1] is the first bit received. 'state' is the number of
    // leading pattern bits already matched. The candidate stream is those
    // matched bits followed by bit_in; the result is the longest proper
    // prefix of the pattern that ends that stream.
    function automatic int next_state(input logic [15:0] pattern,
                                      input int          len,
                                      input int          state,
                                      input logic        bit_in,
                                      input bit          overlap);
        logic [16:0] s;
        int          s_len;
        int          best;
        bit          ok;
        if (state == len - 1 && bit_in == pattern[0] && !overlap)
            return 0;
        s     = '0;
        s_len = state + 1;
        for (int j = 0; j < state; j++)
            s[j] = pattern[len - 1 - j];
        s[state] = bit_in;
        best = 0;
        for (int k = 1; k < len && k <= s_len; k++) begin
            ok = 1'b1;
            for (int m = 0; m < k; m++)
                if (s[s_len - k + m] != pattern[len - 1 - m]) ok = 1'b0;
            if (ok) best = k;
        end
        return best;
    endfunction

endpackage

// File: rtl/mealy_fsm_next.sv
// mealy_fsm_next
//   Pure combinational next-state and Mealy output logic.
//   Ports:
//     state  in  SW  current state (number of pattern bits matched)
//     din    in  1   current serial bit
//     nxt    out SW  state to load at the next rising edge
//     y      out 1   match flag for the current (state, din)
module mealy_fsm_next
    import mealy_fsm_pkg::*;
#(
    parameter int          PAT_LEN = DEF_PAT_LEN,
    parameter logic [15:0] PATTERN = 16'(DEF_PATTERN),
    parameter bit          OVERLAP = 1'b1,
    parameter int          SW      = clog2(PAT_LEN)
) (
    input  logic [SW-1:0] state,
    input  logic          din,
    output logic [SW-1:0] nxt,
    output logic          y
);

    localparam int          NSTATE = 1 << SW;
    localparam logic [SW-1:0] LAST = SW'(PAT_LEN - 1);

    logic [SW-1:0] tbl0 [NSTATE];
    logic [SW-1:0] tbl1 [NSTATE];

    // Transition table fixed at elaboration; encodings >= PAT_LEN fall to S0.
    for (genvar s = 0; s < NSTATE; s++) begin : g_tbl
        localparam int N0 = (s < PAT_LEN) ?
            mealy_fsm_pkg::next_state(PATTERN, PAT_LEN, s, 1'b0, OVERLAP) : 0;
        localparam int N1 = (s < PAT_LEN) ?
            mealy_fsm_pkg::next_state(PATTERN, PAT_LEN, s, 1'b1, OVERLAP) : 0;
        assign tbl0[s] = SW'(N0);
        assign tbl1[s] = SW'(N1);
    end

    always_comb begin
        nxt = '0;
        y   = 1'b0;
        // Ternary on din keeps X propagation honest instead of masking to S0.
        nxt = din ? tbl1[state] : tbl0[state];
        y   = (state == LAST) && (din == PATTERN[0]);
    end

endmodule

// File: rtl/mealy_fsm.sv
// mealy_fsm
//   Overlapping serial bit-pattern detector (Mealy). One bit per clock on din;
//   y is high in the same cycle din carries the final pattern bit.
//   Ports:
//     clk    in  1  clock, rising edge
//     reset  in  1  asynchronous active-low reset
//     din    in  1  serial data bit
//     y      out 1  match flag (combinational from state and din)
//
//   state | meaning (default pattern 1011)
//   S0    | nothing matched
//   S1    | "1" matched
//   S2    | "10" matched
//   S3    | "101" matched; din=1 completes the pattern
module mealy_fsm
    import mealy_fsm_pkg::*;
#(
    parameter int          PAT_LEN = DEF_PAT_LEN,
    parameter logic [15:0] PATTERN = 16'(DEF_PATTERN),
    parameter bit          OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic y
);

    localparam int SW = clog2(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
        $error("mealy_fsm: PAT_LEN must be in 2..16");
    end
    if (PAT_LEN < 16 && (PATTERN >> PAT_LEN) != 16'd0) begin : g_bad_pat
        $error("mealy_fsm: PATTERN has bits set above PAT_LEN-1");
    end

    logic [SW-1:0] state;
    logic [SW-1:0] nxt;
    logic          y_raw;

    mealy_fsm_next #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP),
        .SW      (SW)
    ) u_next (
        .state (state),
        .din   (din),
        .nxt   (nxt),
        .y     (y_raw)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= '0;
        else        state <= nxt;
    end

    assign y = reset & y_raw;

endmodule

// File: tb/tb_mealy_fsm.sv
module tb_mealy_fsm;
    import mealy_fsm_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic din = 1'b0;
    logic y_ov;
    logic y_no;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mealy_fsm dut_ov (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .y     (y_ov)
    );

    mealy_fsm #(.OVERLAP(1'b0)) dut_no (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .y     (y_no)
    );

    typedef struct {
        logic  rst;
        logic  din;
        logic  y_ov;
        logic  y_no;
        string tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic d, input logic eo,
                       input logic en, input string t);
        vec_t v;
        v.rst = r; v.din = d; v.y_ov = eo; v.y_no = en; v.tag = t;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Drive at negedge, sample just before the consuming posedge.
    task automatic step(input logic r, input logic d, input logic eo,
                        input logic en, input string t);
        @(negedge clk);
        reset = r;
        din   = d;
        #4;
        check({t, " y_ov"}, {3'b0, y_ov}, {3'b0, eo});
        check({t, " y_no"}, {3'b0, y_no}, {3'b0, en});
    endtask

    initial begin
        // reset held low, din toggling: y forced low
        add(0, 1, 0, 0, "rst0");
        add(0, 0, 0, 0, "rst1");
        add(0, 1, 0, 0, "rst2");
        // 1,0,1,1 then a trailing 1: y only on 4th bit
        add(1, 1, 0, 0, "p4_b1");
        add(1, 0, 0, 0, "p4_b2");
        add(1, 1, 0, 0, "p4_b3");
        add(1, 1, 1, 1, "p4_b4");
        add(1, 1, 0, 0, "p4_after");
        // overlap stream 1,0,1,1,0,1,1
        add(0, 0, 0, 0, "ov_rst");
        add(1, 1, 0, 0, "ov_b1");
        add(1, 0, 0, 0, "ov_b2");
        add(1, 1, 0, 0, "ov_b3");
        add(1, 1, 1, 1, "ov_b4");
        add(1, 0, 0, 0, "ov_b5");
        add(1, 1, 0, 0, "ov_b6");
        add(1, 1, 1, 0, "ov_b7");
        // 1,1,0,1,1: repeated 1 keeps S1
        add(0, 0, 0, 0, "rp_rst");
        add(1, 1, 0, 0, "rp_b1");
        add(1, 1, 0, 0, "rp_b2");
        add(1, 0, 0, 0, "rp_b3");
        add(1, 1, 0, 0, "rp_b4");
        add(1, 1, 1, 1, "rp_b5");
        // 1,0,1,0,1,1: mismatch in S3 falls to S2, not S0
        add(0, 0, 0, 0, "f2_rst");
        add(1, 1, 0, 0, "f2_b1");
        add(1, 0, 0, 0, "f2_b2");
        add(1, 1, 0, 0, "f2_b3");
        add(1, 0, 0, 0, "f2_b4");
        add(1, 1, 0, 0, "f2_b5");
        add(1, 1, 1, 1, "f2_b6");

        reset = 1'b0;
        din   = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].din, vecs[i].y_ov, vecs[i].y_no, vecs[i].tag);
            if (i == 2) begin
                check("state_after_rst_ov", {2'b0, dut_ov.state}, {2'b0, S0});
                check("state_after_rst_no", {2'b0, dut_no.state}, {2'b0, S0});
            end
        end

        // Mid-cycle async reset from S3, then a fresh 1,0,1,1
        step(0, 0, 0, 0, "mr_rst");
        step(1, 1, 0, 0, "mr_b1");
        step(1, 0, 0, 0, "mr_b2");
        step(1, 1, 0, 0, "mr_b3");
        @(posedge clk);
        #1;
        check("state_s3_ov", {2'b0, dut_ov.state}, {2'b0, S3});
        #2;
        reset = 1'b0;
        din   = 1'b1;
        #1;
        check("async_rst_state_ov", {2'b0, dut_ov.state}, {2'b0, S0});
        check("async_rst_state_no", {2'b0, dut_no.state}, {2'b0, S0});
        check("async_rst_y_ov", {3'b0, y_ov}, 4'd0);
        check("async_rst_y_no", {3'b0, y_no}, 4'd0);
        step(1, 1, 0, 0, "mr2_b1");
        step(1, 0, 0, 0, "mr2_b2");
        step(1, 1, 0, 0, "mr2_b3");
        step(1, 1, 1, 1, "mr2_b4");
        @(posedge clk);
        #1;
        check("post_hit_state_ov", {2'b0, dut_ov.state}, {2'b0, S1});
        check("post_hit_state_no", {2'b0, dut_no.state}, {2'b0, S0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
